// File: rtl/wb_regfile.sv
// Write-back mux, 32-entry GPR file with same-cycle write-through bypass,
// and a valid/ready dump port that streams every register to the debug unit.
module wb_regfile #(
  parameter int NBITS = 32,
  parameter int RBITS = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NBITS-1:0] WB_result,
  input  logic [NBITS-1:0] WB_data,
  input  logic [RBITS-1:0] WB_rd,
  input  logic             WB_memtoreg,
  input  logic             WB_regwrite,
  input  logic [RBITS-1:0] ID_rs,
  input  logic [RBITS-1:0] ID_rt,
  output logic [NBITS-1:0] ID_rs_data,
  output logic [NBITS-1:0] ID_rt_data,
  output logic [NBITS-1:0] WB_wdata,
  input  logic             i_dbg_start,
  input  logic             i_dbg_ready,
  output logic             o_dbg_valid,
  output logic [RBITS-1:0] o_dbg_addr,
  output logic [NBITS-1:0] o_dbg_data,
  output logic             o_dbg_busy,
  output logic             o_dbg_done
);
  localparam int NREGS = 2 ** RBITS;
  localparam logic [RBITS-1:0] LAST_ADDR = RBITS'(NREGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE} state_t;

  logic [NBITS-1:0] w_wdata;
  logic             w_commit;
  logic [NBITS-1:0] w_rf [0:NREGS-1];
  logic [RBITS-1:0] w_dump_idx;
  logic [NBITS-1:0] w_dump_word;

  state_t           r_state, w_state_next;
  logic [RBITS-1:0] r_addr, w_addr_next;
  logic [NBITS-1:0] r_data, w_data_next;

  assign w_wdata  = WB_memtoreg ? WB_data : WB_result;
  assign WB_wdata = w_wdata;
  assign w_commit = WB_regwrite && (WB_rd != '0);

  // r0 is hard-wired to zero; only r1..r31 hold state.
  assign w_rf[0] = '0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [NBITS-1:0] r_q;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
          r_q <= '0;
        else if (w_commit && (WB_rd == RBITS'(gi)))
          r_q <= w_wdata;
      end
      assign w_rf[gi] = r_q;
    end
  endgenerate

  assign ID_rs_data = (ID_rs == '0) ? '0 :
                      (WB_regwrite && (WB_rd == ID_rs)) ? w_wdata : w_rf[ID_rs];
  assign ID_rt_data = (ID_rt == '0) ? '0 :
                      (WB_regwrite && (WB_rd == ID_rt)) ? w_wdata : w_rf[ID_rt];

  // The dump captures the post-edge contents, so a coinciding write is seen.
  assign w_dump_idx  = (r_state == S_DUMP) ? (r_addr + RBITS'(1)) : '0;
  assign w_dump_word = (w_dump_idx == '0) ? '0 :
                       (w_commit && (WB_rd == w_dump_idx)) ? w_wdata : w_rf[w_dump_idx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    case (r_state)
      S_IDLE: begin
        if (i_dbg_start) begin
          w_state_next = S_DUMP;
          w_addr_next  = '0;
          w_data_next  = w_dump_word;
        end
      end
      S_DUMP: begin
        if (i_dbg_ready) begin
          if (r_addr == LAST_ADDR) begin
            w_state_next = S_DONE;
          end else begin
            w_addr_next = w_dump_idx;
            w_data_next = w_dump_word;
          end
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_dbg_valid = (r_state == S_DUMP);
  assign o_dbg_busy  = (r_state != S_IDLE);
  assign o_dbg_done  = (r_state == S_DONE);
  assign o_dbg_addr  = r_addr;
  assign o_dbg_data  = r_data;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: write-back mux, bypass, r0 rules, dump FSM
// with backpressure, coinciding writes and mid-dump reset.
module tb_wb_regfile;
  logic        clk;
  logic        rst;
  logic [31:0] wb_result, wb_data;
  logic [4:0]  wb_rd;
  logic        wb_memtoreg, wb_regwrite;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_rs_data, id_rt_data, wb_wdata;
  logic        dbg_start, dbg_ready;
  logic        dbg_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_busy, dbg_done;

  int checks = 0;
  int failures = 0;

  wb_regfile #(.NBITS(32), .RBITS(5)) dut (
    .i_clk(clk), .i_rst(rst),
    .WB_result(wb_result), .WB_data(wb_data), .WB_rd(wb_rd),
    .WB_memtoreg(wb_memtoreg), .WB_regwrite(wb_regwrite),
    .ID_rs(id_rs), .ID_rt(id_rt),
    .ID_rs_data(id_rs_data), .ID_rt_data(id_rt_data), .WB_wdata(wb_wdata),
    .i_dbg_start(dbg_start), .i_dbg_ready(dbg_ready),
    .o_dbg_valid(dbg_valid), .o_dbg_addr(dbg_addr), .o_dbg_data(dbg_data),
    .o_dbg_busy(dbg_busy), .o_dbg_done(dbg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] val);
    wb_regwrite = 1'b1; wb_memtoreg = 1'b0; wb_rd = rd; wb_result = val;
    step();
    wb_regwrite = 1'b0;
  endtask

  task automatic start_dump();
    dbg_start = 1'b1;
    step();
    dbg_start = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_result = '0; wb_data = '0; wb_rd = '0;
    wb_memtoreg = 1'b0; wb_regwrite = 1'b0;
    id_rs = '0; id_rt = '0;
    dbg_start = 1'b0; dbg_ready = 1'b0;
    #1;
    chk("rst_valid", {31'd0, dbg_valid}, 32'd0);
    chk("rst_busy",  {31'd0, dbg_busy},  32'd0);
    chk("rst_done",  {31'd0, dbg_done},  32'd0);
    chk("rst_addr",  {27'd0, dbg_addr},  32'd0);
    chk("rst_data",  dbg_data,           32'd0);
    step(); step();
    rst = 1'b0;
    step();

    $display("step: reset read-back of all registers");
    for (int i = 0; i < 32; i++) begin
      id_rs = 5'(i); id_rt = 5'(31 - i);
      #1;
      chk("rst_rs", id_rs_data, 32'd0);
      chk("rst_rt", id_rt_data, 32'd0);
    end

    $display("step: write 0xDEAD to r0");
    wb_regwrite = 1'b1; wb_memtoreg = 1'b0; wb_rd = 5'd0; wb_result = 32'hDEAD; id_rs = 5'd0;
    #1;
    chk("r0_wdata",  wb_wdata,   32'hDEAD);
    chk("r0_bypass", id_rs_data, 32'd0);
    step();
    wb_regwrite = 1'b0;
    #1;
    chk("r0_read", id_rs_data, 32'd0);

    $display("step: memtoreg selects load data");
    wb_regwrite = 1'b1; wb_rd = 5'd7; wb_memtoreg = 1'b1; wb_data = 32'd8; wb_result = 32'd9;
    #1;
    chk("wdata_mem", wb_wdata, 32'd8);
    step();
    wb_regwrite = 1'b0; id_rs = 5'd7;
    #1;
    chk("r7_mem", id_rs_data, 32'd8);

    $display("step: memtoreg=0 selects ALU result");
    wb_regwrite = 1'b1; wb_memtoreg = 1'b0;
    #1;
    chk("wdata_alu", wb_wdata, 32'd9);
    step();
    wb_regwrite = 1'b0; id_rt = 5'd7;
    #1;
    chk("r7_alu", id_rt_data, 32'd9);

    $display("step: write-through bypass on r5");
    wb_regwrite = 1'b0; wb_rd = 5'd5; wb_memtoreg = 1'b0; wb_result = 32'd7; id_rs = 5'd5; id_rt = 5'd5;
    #1;
    chk("nobypass_rs", id_rs_data, 32'd0);
    wb_regwrite = 1'b1;
    #1;
    chk("bypass_rs", id_rs_data, 32'd7);
    chk("bypass_rt", id_rt_data, 32'd7);
    step();
    wb_regwrite = 1'b0; wb_result = 32'd99;
    #1;
    chk("r5_commit", id_rs_data, 32'd7);

    $display("step: preload rK = K*3 and dump with ready high");
    for (int k = 1; k < 32; k++) wr(5'(k), 32'(k * 3));
    dbg_ready = 1'b1;
    start_dump();
    chk("dump_busy0", {31'd0, dbg_busy}, 32'd1);
    for (int k = 0; k < 32; k++) begin
      chk("dump_valid", {31'd0, dbg_valid}, 32'd1);
      chk("dump_addr",  {27'd0, dbg_addr},  32'(k));
      chk("dump_data",  dbg_data,           32'(k * 3));
      chk("dump_ndone", {31'd0, dbg_done},  32'd0);
      step();
    end
    chk("done_pulse", {31'd0, dbg_done},  32'd1);
    chk("done_valid", {31'd0, dbg_valid}, 32'd0);
    chk("done_busy",  {31'd0, dbg_busy},  32'd1);
    step();
    chk("idle_done", {31'd0, dbg_done}, 32'd0);
    chk("idle_busy", {31'd0, dbg_busy}, 32'd0);

    $display("step: backpressure at addr 10 with concurrent write");
    start_dump();
    for (int k = 0; k < 10; k++) step();
    chk("bp_addr_pre", {27'd0, dbg_addr}, 32'd10);
    dbg_ready = 1'b0;
    wb_regwrite = 1'b1; wb_memtoreg = 1'b0; wb_rd = 5'd10; wb_result = 32'h55;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_valid", {31'd0, dbg_valid}, 32'd1);
      chk("bp_addr",  {27'd0, dbg_addr},  32'd10);
      chk("bp_data",  dbg_data,           32'd30);
    end
    wb_regwrite = 1'b0;
    dbg_ready = 1'b1;
    step();
    chk("bp_addr_adv", {27'd0, dbg_addr}, 32'd11);
    chk("bp_data_adv", dbg_data,          32'd33);
    id_rs = 5'd10;
    #1;
    chk("r10_written", id_rs_data, 32'h55);

    $display("step: reset mid-dump at addr 20");
    for (int k = 0; k < 9; k++) step();
    chk("pre_rst_addr", {27'd0, dbg_addr}, 32'd20);
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, dbg_valid}, 32'd0);
    chk("mrst_busy",  {31'd0, dbg_busy},  32'd0);
    chk("mrst_done",  {31'd0, dbg_done},  32'd0);
    chk("mrst_addr",  {27'd0, dbg_addr},  32'd0);
    id_rs = 5'd10; id_rt = 5'd31;
    #1;
    chk("mrst_r10", id_rs_data, 32'd0);
    chk("mrst_r31", id_rt_data, 32'd0);
    step();
    chk("mrst_hold_done", {31'd0, dbg_done}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_done", {31'd0, dbg_done}, 32'd0);

    $display("step: restart dump, coinciding write to r2 captured");
    start_dump();
    chk("rs_addr0",  {27'd0, dbg_addr},  32'd0);
    chk("rs_valid0", {31'd0, dbg_valid}, 32'd1);
    step();
    chk("rs_addr1", {27'd0, dbg_addr}, 32'd1);
    chk("rs_data1", dbg_data,          32'd0);
    wb_regwrite = 1'b1; wb_memtoreg = 1'b1; wb_rd = 5'd2; wb_data = 32'h77; wb_result = 32'h11;
    step();
    wb_regwrite = 1'b0;
    chk("rs_addr2", {27'd0, dbg_addr}, 32'd2);
    chk("rs_data2", dbg_data,          32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
